// File: rtl/wave_fifo_reader.sv
// wave_fifo_reader: read-side engine for the waveform sample FIFO.
// Prefetches samples into a 4-entry buffer to hide the FIFO's registered
// read latency, then emits one sample per programmable period to the DAC.
`timescale 1ns/1ps
module wave_fifo_reader #(
  parameter int p_nbit_d   = 16,
  parameter int p_rd_lat   = 2,
  parameter int p_nbit_div = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [p_nbit_div-1:0] div,
  input  logic                  clr_underrun,
  output logic                  fifo_rd,
  input  logic [p_nbit_d-1:0]   fifo_rdata,
  input  logic                  fifo_empty,
  output logic [p_nbit_d-1:0]   dac_data,
  output logic                  dac_strobe,
  output logic                  underrun,
  output logic                  busy,
  output logic [2:0]            level
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [p_nbit_div-1:0] CNT_ONE = 1;

  state_t                state_q, state_d;
  logic [p_nbit_div-1:0] cnt_q, cnt_d;
  logic [p_rd_lat:1]     vld_pipe_q;          // stage i: read issued i cycles ago
  logic [p_nbit_d-1:0]   mem_q [4];
  logic [1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0]            occ_q, occ_d;
  logic [p_nbit_d-1:0]   dac_data_q, dac_data_d;
  logic                  strobe_q, strobe_d;
  logic                  under_q, under_d;

  logic [3:0] inflight, fill;
  logic       push, pop, tick, run;

  // Read request: keep buffer plus reads in flight at most 4. Gated by rst_n
  // so no read escapes while the shared reset is held.
  always_comb begin
    inflight = '0;
    for (int i = 1; i <= p_rd_lat; i++) inflight = inflight + {3'b000, vld_pipe_q[i]};
    fill    = {1'b0, occ_q} + inflight;
    fifo_rd = rst_n & ~fifo_empty & (fill < 4'd4);
    push    = vld_pipe_q[p_rd_lat];
  end

  // Valid shift register mirroring the FIFO's read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[1] <= fifo_rd;
      for (int i = 2; i <= p_rd_lat; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: start once a sample is buffered; dropping en wins over a tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en && occ_q != 3'd0) state_d = S_RUN;
      S_RUN:   if (!en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Tick counter, buffer pointers, output and underrun next-state.
  always_comb begin
    run        = (state_q == S_RUN);
    tick       = run & en & (cnt_q >= div);
    pop        = tick & (occ_q != 3'd0);
    cnt_d      = '0;
    if (run && en) cnt_d = tick ? '0 : cnt_q + CNT_ONE;
    wptr_d     = push ? wptr_q + 2'd1 : wptr_q;
    rptr_d     = pop  ? rptr_q + 2'd1 : rptr_q;
    occ_d      = occ_q;
    if (push && !pop)      occ_d = occ_q + 3'd1;
    else if (!push && pop) occ_d = occ_q - 3'd1;
    dac_data_d = pop ? mem_q[rptr_q] : dac_data_q;
    strobe_d   = pop;
    under_d    = under_q;
    if (tick && occ_q == 3'd0) under_d = 1'b1;
    else if (clr_underrun)     under_d = 1'b0;
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      dac_data_q <= '0;
      strobe_q   <= 1'b0;
      under_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
      dac_data_q <= dac_data_d;
      strobe_q   <= strobe_d;
      under_q    <= under_d;
    end
  end

  // Buffer storage; contents are don't-care while occ is 0, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= fifo_rdata;
  end

  assign dac_data   = dac_data_q;
  assign dac_strobe = strobe_q;
  assign underrun   = under_q;
  assign busy       = (state_q == S_RUN);
  assign level      = occ_q;

  // The read-request rule must make buffer overflow unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && occ_q == 3'd4));
  a_fill_bound: assert property (@(posedge clk) disable iff (!rst_n) fill <= 4'd4);

endmodule

// File: doc/wave_fifo_reader.md
# wave_fifo_reader

Read-side engine for the waveform sample FIFO (`sync_fifo`). It pops samples through the FIFO's `rd`/`rdata`/`empty` port and hides the FIFO's registered read latency with a 4-entry prefetch buffer. It then emits one sample to the DAC interface per programmable sample period. Underruns are reported through a sticky flag.

## Interface
Parameters:
- `p_nbit_d`, 16: sample width; equals the FIFO data width.
- `p_rd_lat`, 2: cycles from `fifo_rd` to valid `fifo_rdata`. Legal values are 1 and 2; use 2 for FIFO optlevel 3 and 1 for optlevels 1–2.
- `p_nbit_div`, 16: width of the sample-period divider.

Ports:
- `clk`  in  1  single clock; the FIFO uses the same clock.
- `rst_n`  in  1  asynchronous, active-low reset; shared with the FIFO.
- `en`  in  1  run enable.
- `div`  in  p_nbit_div  sample period minus 1, in clocks.
- `clr_underrun`  in  1  one-cycle pulse that clears `underrun`.
- `fifo_rd`  out  1  read request to the FIFO.
- `fifo_rdata`  in  p_nbit_d  FIFO read data.
- `fifo_empty`  in  1  FIFO empty flag.
- `dac_data`  out  p_nbit_d  registered sample; holds its last value between strobes.
- `dac_strobe`  out  1  one-cycle pulse marking a new `dac_data` value.
- `underrun`  out  1  sticky flag: a tick found the buffer empty.
- `busy`  out  1  high while the state is RUN.
- `level`  out  3  prefetch buffer occupancy, 0–4.

## Operation
- Prefetch:
  - `fifo_rd = ~fifo_empty & (occ + inflight < 4)`. This is combinational and independent of `en` and state, so the buffer fills while IDLE.
  - A `p_rd_lat`-deep valid shift register tracks `inflight`.
  - On its output, `fifo_rdata` is pushed into the buffer. The buffer is a FIFO of depth 4 with 2-bit pointers and wrap-around.
- Buffer:
  - Push and pop in the same cycle are legal; `occ` is unchanged.
  - A push when `occ + inflight` would exceed 4 is impossible by construction. Add an assertion for it.
- State machine:
  - IDLE → RUN when `en=1` and `occ ≥ 1`.
  - RUN → IDLE when `en=0`; this takes priority over any tick in the same cycle.
  - An underrun does not leave RUN.
- Tick counter `cnt`:
  - Held at 0 in IDLE.
  - In RUN, `tick = (cnt >= div)`. On a tick `cnt` goes to 0; otherwise it increments.
  - A `div` change takes effect immediately. If `cnt > div`, the next cycle ticks.
- On a tick with `occ > 0`: pop the buffer head into `dac_data` and assert `dac_strobe` next cycle.
- On a tick with `occ = 0`: set `underrun`. `dac_data` holds and there is no strobe.
- `underrun` is cleared by `clr_underrun`. If a set and a clear occur in the same cycle, the set wins.
- Leaving RUN keeps all buffered and in-flight samples. None are lost or duplicated on resume.

## Timing
- Reset values: `fifo_rd=0`, `dac_data=0`, `dac_strobe=0`, `underrun=0`, `busy=0`, `level=0`, state IDLE, `cnt=0`, buffer and valid pipe empty. Reset acts immediately, without a clock edge.
- Read latency: `fifo_rd` is high in cycle t, `fifo_rdata` is captured at the end of cycle t+`p_rd_lat`, and the sample is poppable from cycle t+`p_rd_lat`+1.
- Output latency: a tick in cycle t gives `dac_strobe` and the new `dac_data` in cycle t+1.
- Cold start with `p_rd_lat=2`, `en` held high, FIFO non-empty at cycle 0:
  - `occ=1` at cycle 3.
  - RUN at cycle 4.
  - With `div=0`, first tick at cycle 4 and first strobe at cycle 5.
- Throughput: with `div=0` and the FIFO kept non-empty, one strobe per clock with no bubbles for both `p_rd_lat` values.
- Strobe spacing is exactly `div+1` clocks while samples are available.

## Test plan
- Reset: assert `rst_n=0` between clock edges. All outputs go to their reset values immediately, and `fifo_rd=0` even if `fifo_empty=0`.
- Cold start and throughput:
  - Setup: `p_rd_lat=2`, FIFO preloaded with 0x0001..0x0008, `div=0`, `en=1` at cycle 0.
  - Required: strobes in cycles 5..12 carrying 0x0001..0x0008. `underrun` rises in cycle 13 and `dac_data` stays 0x0008.
- Rate:
  - Setup: `div=3`, 6 samples queued.
  - Required: strobes exactly 4 cycles apart. Changing `div` to 1 mid-run makes the next strobe come at most 2 cycles after the previous one.
- Pause:
  - Setup: drop `en` after the 3rd strobe, then raise it 10 cycles later.
  - Required: no strobe while IDLE and `level=4`. On resume, the 4th sample follows the 3rd with no gap in the data sequence.
- Underrun flag:
  - Setup: FIFO empty while in RUN.
  - Required: `underrun=1` after the first tick. A `clr_underrun` pulse on the same cycle as a new underrun tick leaves it at 1; a pulse with no tick clears it.
- Latency variant: with `p_rd_lat=1`, the same stimulus as the cold-start test gives the first strobe in cycle 4 and back-to-back data.
